// File: rtl/io_timer_responder.sv
`timescale 1ns/1ps
// Memory-mapped down-counting timer with a start/busy access handshake.
// An 8-word register window at BASE holds CTRL, LOAD, COUNT, STATUS and PRESCALE.
module io_timer_responder #(
    parameter logic [26:0] BASE = 27'h7000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [26:0] address,
    input  logic [31:0] data,
    input  logic        we,
    input  logic        start,
    output logic        busy,
    output logic [31:0] q,
    output logic        irq,
    output logic [1:0]  dbg_state_o
);

    // Handshake: the initiator raises start and holds address/data/we until it
    // sees busy fall; busy drops after the ACCESS edge, and the initiator must
    // drop start before the next access can be accepted.
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [26:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;

    logic        en_q, en_d, auto_q, auto_d, ie_q, ie_d;
    logic [31:0] load_q, load_d, count_q, count_d;
    logic        exp_q, exp_d;
    logic [15:0] prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;
    logic [31:0] q_q, q_d;
    logic        irq_q, irq_d;

    logic        hit, acc_wr, acc_rd, tick, expire;
    logic [2:0]  off;
    logic [31:0] rdata;

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = start;
                if (start) state_d = ACCESS;
            end
            ACCESS: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE:    if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                addr_q  <= address;
                wdata_q <= data;
                we_q    <= we;
            end
        end
    end

    assign hit    = (addr_q[26:3] == BASE[26:3]);
    assign off    = addr_q[2:0];
    assign acc_wr = (state_q == ACCESS) && we_q && hit;
    assign acc_rd = (state_q == ACCESS) && !we_q;
    assign tick   = en_q && (pre_cnt_q == prescale_q);
    assign expire = tick && (count_q <= 32'd1);

    always_comb begin
        rdata = '0;
        case (off)
            3'd0:    rdata = {29'd0, ie_q, auto_q, en_q};
            3'd1:    rdata = load_q;
            3'd2:    rdata = count_q;
            3'd3:    rdata = {31'd0, exp_q};
            3'd4:    rdata = {16'd0, prescale_q};
            default: rdata = '0;
        endcase
    end

    always_comb begin
        en_d       = en_q;
        auto_d     = auto_q;
        ie_d       = ie_q;
        load_d     = load_q;
        count_d    = count_q;
        exp_d      = exp_q;
        prescale_d = prescale_q;
        pre_cnt_d  = pre_cnt_q;
        q_d        = q_q;
        irq_d      = expire && ie_q;

        if (en_q) pre_cnt_d = tick ? 16'd0 : pre_cnt_q + 16'd1;
        if (tick) count_d = expire ? (auto_q ? load_q : 32'd0) : count_q - 32'd1;
        if (expire) begin
            exp_d = 1'b1;
            if (!auto_q) en_d = 1'b0;
        end

        // Bus writes land after the timer update so a written CTRL wins over expiry.
        if (acc_wr) begin
            case (off)
                3'd0: begin
                    en_d   = wdata_q[0];
                    auto_d = wdata_q[1];
                    ie_d   = wdata_q[2];
                    if (!en_q && wdata_q[0]) begin
                        count_d   = load_q;
                        pre_cnt_d = 16'd0;
                    end
                end
                3'd1:    load_d = wdata_q;
                3'd3:    if (wdata_q[0] && !expire) exp_d = 1'b0;
                3'd4:    prescale_d = wdata_q[15:0];
                default: ;
            endcase
        end

        if (acc_rd) q_d = hit ? rdata : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            ie_q       <= 1'b0;
            load_q     <= '0;
            count_q    <= '0;
            exp_q      <= 1'b0;
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            q_q        <= '0;
            irq_q      <= 1'b0;
        end else begin
            en_q       <= en_d;
            auto_q     <= auto_d;
            ie_q       <= ie_d;
            load_q     <= load_d;
            count_q    <= count_d;
            exp_q      <= exp_d;
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            q_q        <= q_d;
            irq_q      <= irq_d;
        end
    end

    assign q           = q_q;
    assign irq         = irq_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_io_timer_responder.sv
`timescale 1ns/1ps
// Directed and randomized bench for io_timer_responder against a register-level
// model of the timer updated once per rising edge.
module tb_io_timer_responder;

    localparam logic [26:0] BASE = 27'h7000000;

    logic        clk = 1'b0;
    logic        reset, we, start, busy, irq;
    logic [26:0] address;
    logic [31:0] data, q;
    logic [1:0]  dbg_state_o;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    int acc_edge = 0;
    int irq_edges[$];

    // model of the programmer-visible state
    logic        m_en, m_auto, m_ie, m_exp, m_irq;
    logic [31:0] m_load, m_count, m_q;
    logic [15:0] m_pre, m_pre_cnt;

    io_timer_responder #(.BASE(BASE)) dut (
        .clk(clk), .reset(reset), .address(address), .data(data), .we(we),
        .start(start), .busy(busy), .q(q), .irq(irq), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0; m_irq = 0;
        m_load = 0; m_count = 0; m_q = 0; m_pre = 0; m_pre_cnt = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] o);
        case (o)
            3'd0:    return {29'd0, m_ie, m_auto, m_en};
            3'd1:    return m_load;
            3'd2:    return m_count;
            3'd3:    return {31'd0, m_exp};
            3'd4:    return {16'd0, m_pre};
            default: return 32'd0;
        endcase
    endfunction

    // One rising edge of the timer, with an optional bus access completing on it.
    task automatic model_edge(input bit acc, input bit w, input logic [26:0] a, input logic [31:0] d);
        bit          is_hit, ticked, expired, was_en;
        logic [31:0] was_load, rd;
        is_hit   = (a[26:3] == BASE[26:3]);
        rd       = is_hit ? model_read(a[2:0]) : 32'd0;
        was_en   = m_en;
        was_load = m_load;
        ticked   = m_en && (m_pre_cnt == m_pre);
        expired  = ticked && (m_count <= 1);
        m_irq    = expired && m_ie;
        if (m_en) m_pre_cnt = ticked ? 16'd0 : m_pre_cnt + 16'd1;
        if (ticked && !expired) m_count = m_count - 1;
        if (expired) begin
            m_exp = 1;
            if (m_auto) m_count = was_load;
            else begin
                m_count = 0;
                m_en = 0;
            end
        end
        if (acc && w && is_hit) begin
            if (a[2:0] == 3'd0) begin
                m_en = d[0]; m_auto = d[1]; m_ie = d[2];
                if (!was_en && d[0]) begin
                    m_count = was_load;
                    m_pre_cnt = 0;
                end
            end else if (a[2:0] == 3'd1) m_load = d;
            else if (a[2:0] == 3'd3 && d[0] && !expired) m_exp = 0;
            else if (a[2:0] == 3'd4) m_pre = d[15:0];
        end
        if (acc && !w) m_q = rd;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic clk_edge(input bit acc, input bit w, input logic [26:0] a, input logic [31:0] d);
        @(posedge clk);
        edge_n++;
        if (reset) model_reset();
        else model_edge(acc, w, a, d);
        @(negedge clk);
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
        if (irq === 1'b1) irq_edges.push_back(edge_n);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            clk_edge(0, 0, '0, '0);
            chk("busy_idle", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic bus_access(input bit w, input logic [26:0] a, input logic [31:0] d);
        address = a; data = d; we = w; start = 1'b1;
        #1;
        chk("busy_rise", {31'd0, busy}, 32'd1);
        clk_edge(0, 0, '0, '0);
        chk("busy_access", {31'd0, busy}, 32'd1);
        chk("state_access", {30'd0, dbg_state_o}, 32'd1);
        acc_edge = edge_n + 1;
        clk_edge(1, w, a, d);
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("state_done", {30'd0, dbg_state_o}, 32'd2);
        chk("q", q, m_q);
        clk_edge(0, 0, '0, '0);
        chk("busy_held", {31'd0, busy}, 32'd0);
        chk("state_held", {30'd0, dbg_state_o}, 32'd2);
        start = 1'b0;
        clk_edge(0, 0, '0, '0);
        chk("state_back_idle", {30'd0, dbg_state_o}, 32'd0);
        chk("busy_back_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [26:0] ra;
        logic [31:0] rd;
        bit          rw;
        reset = 1'b1; start = 1'b0; we = 1'b0; address = '0; data = '0;
        model_reset();
        @(negedge clk);
        clk_edge(0, 0, '0, '0);
        clk_edge(0, 0, '0, '0);
        reset = 1'b0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_q", q, 32'd0);
        chk("reset_state", {30'd0, dbg_state_o}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            bus_access(0, BASE + 27'(i), '0);
            chk("reset_reg", q, 32'd0);
        end

        // write then read LOAD
        bus_access(1, BASE + 27'd1, 32'd5);
        bus_access(0, BASE + 27'd1, '0);
        chk("load_readback", q, 32'd5);

        // one-shot expiry with irq three edges after enabling
        bus_access(1, BASE + 27'd4, 32'd0);
        bus_access(1, BASE + 27'd1, 32'd3);
        irq_edges.delete();
        bus_access(1, BASE + 27'd0, 32'h5);
        idle(6);
        chk("oneshot_irq_count", 32'(irq_edges.size()), 32'd1);
        if (irq_edges.size() > 0) chk("oneshot_irq_delay", 32'(irq_edges[0] - acc_edge), 32'd3);
        bus_access(0, BASE + 27'd3, '0);
        chk("oneshot_exp", q, 32'd1);
        bus_access(0, BASE + 27'd0, '0);
        chk("oneshot_ctrl", q, 32'h4);
        bus_access(0, BASE + 27'd2, '0);
        chk("oneshot_count", q, 32'd0);

        // auto-reload with prescale 1
        bus_access(1, BASE + 27'd3, 32'd1);
        bus_access(1, BASE + 27'd4, 32'd1);
        bus_access(1, BASE + 27'd1, 32'd2);
        irq_edges.delete();
        bus_access(1, BASE + 27'd0, 32'h7);
        idle(14);
        chk("auto_irq_count", 32'(irq_edges.size()), 32'd4);
        if (irq_edges.size() > 0) chk("auto_first_irq", 32'(irq_edges[0] - acc_edge), 32'd4);
        for (int i = 1; i < irq_edges.size(); i++)
            chk("auto_irq_period", 32'(irq_edges[i] - irq_edges[i-1]), 32'd4);
        bus_access(0, BASE + 27'd0, '0);
        chk("auto_ctrl", q, 32'h7);
        bus_access(1, BASE + 27'd0, 32'd0);

        // miss read and ignored COUNT write
        bus_access(1, BASE + 27'd2, 32'd1234);
        bus_access(0, 27'h0000010, '0);
        chk("miss_q", q, 32'd0);
        bus_access(0, BASE + 27'd2, '0);
        chk("count_ro", q, m_count);

        // expiry every tick colliding with a STATUS clear
        bus_access(1, BASE + 27'd3, 32'd1);
        bus_access(1, BASE + 27'd4, 32'd0);
        bus_access(1, BASE + 27'd1, 32'd0);
        bus_access(1, BASE + 27'd0, 32'h3);
        bus_access(1, BASE + 27'd3, 32'd1);
        bus_access(0, BASE + 27'd3, '0);
        chk("exp_set_wins", q, 32'd1);
        bus_access(1, BASE + 27'd0, 32'd0);
        bus_access(1, BASE + 27'd3, 32'd1);
        bus_access(0, BASE + 27'd3, '0);
        chk("exp_cleared", q, 32'd0);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            rw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) ra = 27'($urandom);
            else ra = BASE + 27'($urandom_range(0, 7));
            case (ra[2:0])
                3'd0:    rd = $urandom_range(0, 7);
                3'd1:    rd = $urandom_range(0, 6);
                3'd4:    rd = $urandom_range(0, 3);
                default: rd = $urandom;
            endcase
            bus_access(rw, ra, rd);
            idle($urandom_range(0, 3));
        end

        // reset aborting a LOAD write in ACCESS
        address = BASE + 27'd1; data = 32'd9; we = 1'b1; start = 1'b1;
        clk_edge(0, 0, '0, '0);
        chk("abort_in_access", {30'd0, dbg_state_o}, 32'd1);
        reset = 1'b1; start = 1'b0;
        clk_edge(0, 0, '0, '0);
        chk("abort_state", {30'd0, dbg_state_o}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        bus_access(0, BASE + 27'd1, '0);
        chk("abort_load", q, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_timer_responder.md
IO_TIMER_RESPONDER -- requirements
Module: io_timer_responder

Interface
REQ-001 SHALL have parameter BASE, default 27'h7000000, word address of an 8-word register window; BASE[2:0] SHALL be zero.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port address  input  27  word address, held stable by the initiator while start=1.
REQ-005 SHALL have port data  input  32  write data, held stable while start=1.
REQ-006 SHALL have port we  input  1  1=write, 0=read, held stable while start=1.
REQ-007 SHALL have port start  input  1  access request level from the initiator.
REQ-008 SHALL have port busy  output  1  high while the access is in progress.
REQ-009 SHALL have port q  output  32  read data, valid once busy falls.
REQ-010 SHALL have port irq  output  1  one-cycle timer expiry pulse.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-012 IDLE: start=1 at an edge SHALL latch address/data/we and go to ACCESS; otherwise stay in IDLE.
REQ-013 ACCESS: SHALL perform the register read or write at the next edge, register q, and go to DONE.
REQ-014 DONE: SHALL stay until start=0 is sampled, then go to IDLE; a held start SHALL NOT retrigger an access.
REQ-015 busy SHALL be combinational: (state==IDLE && start) || state==ACCESS, so busy is high in the same cycle that start rises; busy SHALL be high for exactly 2 cycles per access.
REQ-016 q SHALL hold its value until the next read completes; a write SHALL leave q unchanged.
REQ-017 The block SHALL decode a hit as address[26:3]==BASE[26:3] and select the register with offset address[2:0].
REQ-018 A miss SHALL still complete the handshake with identical timing, return q=0, and ignore writes.
REQ-019 Offset 0 CTRL (RW): bit0 EN, bit1 AUTO (auto-reload), bit2 IE (irq enable); bits 31:3 SHALL read 0.
REQ-020 Offset 1 LOAD (RW): 32-bit reload value.
REQ-021 Offset 2 COUNT (RO): current count; writes SHALL be ignored.
REQ-022 Offset 3 STATUS: bit0 EXP; writing 1 to bit0 SHALL clear EXP; bits 31:1 SHALL read 0.
REQ-023 Offset 4 PRESCALE (RW): 16 bits; bits 31:16 SHALL read 0.
REQ-024 Offsets 5-7 SHALL read 0, and writes to them SHALL be ignored.
REQ-025 A CTRL write changing EN from 0 to 1 SHALL copy LOAD into COUNT and clear the prescaler counter.
REQ-026 While EN=1, a 16-bit prescaler counter SHALL increment every cycle; when it equals PRESCALE, it SHALL wrap to 0 and generate a tick (PRESCALE=0 gives a tick every cycle).
REQ-027 On a tick with COUNT>1, COUNT SHALL decrement by 1.
REQ-028 On a tick with COUNT<=1 (expiry), the block SHALL set EXP, assert irq for 1 cycle if IE=1, then load COUNT from LOAD if AUTO=1, else set COUNT=0 and clear EN.
REQ-029 LOAD=0 with AUTO=1 SHALL expire on every tick.
REQ-030 Same-edge conflicts:
- Expiry and a STATUS write-1-clear on the same edge SHALL leave EXP=1 (set wins).
- A CTRL write and an expiry on the same edge SHALL give priority to the written CTRL value.
REQ-031 While EN=0, COUNT and the prescaler counter SHALL hold their values.
REQ-032 Register state SHALL NOT depend on the bus FSM; the timer SHALL run during accesses.

Reset
REQ-033 reset=1 at an edge SHALL set the state to IDLE and set CTRL, LOAD, COUNT, STATUS, PRESCALE, the prescaler counter, q and irq to 0; busy SHALL follow REQ-015.
REQ-034 Reset SHALL override any access in progress; the aborted access SHALL have no register effect.
REQ-035 Reset SHALL take priority over start in the same cycle.

Verification
REQ-036 Write LOAD=32'd5 at BASE+1, then read BASE+1 -> busy high 2 cycles each, q=32'd5, busy low while start still held, no second access.
REQ-037 PRESCALE=0, LOAD=3, CTRL=32'h5 -> COUNT reads 3,2,1 on successive cycles; EXP=1 and a 1-cycle irq 3 cycles after the enabling write; CTRL reads 32'h4.
REQ-038 PRESCALE=1, LOAD=2, CTRL=32'h7 -> irq every 4 cycles, COUNT reloads to 2, EN stays 1.
REQ-039 Read 27'h0000010 (a miss) -> q=0, 2-cycle busy; write to BASE+2 -> COUNT unchanged.
REQ-040 Expiry and a STATUS write of 1 on the same edge -> EXP reads 1; a later STATUS write of 1 -> EXP reads 0.
REQ-041 Assert reset during ACCESS of a write to LOAD=9 -> next cycle state is IDLE, busy=0 with start=0, LOAD reads 0.
